// File: rtl/video_timing_pkg.sv
// Shared types for the video timing generator: pixel source modes,
// FSM state codes and the colour-bar lookup.
package video_timing_pkg;

  typedef enum logic [1:0] {
    M_STREAM = 2'd0,
    M_BARS   = 2'd1,
    M_SOLID  = 2'd2,
    M_BLACK  = 2'd3
  } mode_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // {r,g,b} component enables; the caller widens each bit to a full component
  function automatic logic [2:0] bar_rgb(
    input logic [2:0] idx
  );
    logic [2:0] c;
    case (idx)
      3'd0: c = 3'b111;
      3'd1: c = 3'b110;
      3'd2: c = 3'b011;
      3'd3: c = 3'b010;
      3'd4: c = 3'b101;
      3'd5: c = 3'b100;
      3'd6: c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Valid/ready pixel stream feeding the timing generator.
// master = pixel source, slave = timing generator.
interface video_timing_gen_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  px_valid;
  logic [DATA_WIDTH-1:0] px_data;
  logic                  px_ready;

  modport master (
    output px_valid,
    output px_data,
    input  px_ready
  );

  modport slave (
    input  px_valid,
    input  px_data,
    output px_ready
  );
endinterface

// File: rtl/video_raster_cnt.sv
// Horizontal/vertical raster counters with region decode.
// Line and frame order: front porch, sync, back porch, active.
module video_raster_cnt #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic h_active,
  output logic v_active,
  output logic h_first,
  output logic hsync,
  output logic vsync,
  output logic frame_start,
  output logic frame_last
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SY0  = HW'(HFP);
  localparam logic [HW-1:0] H_SY1  = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT  = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SY0  = VW'(VFP);
  localparam logic [VW-1:0] V_SY1  = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT  = VW'(VFP + VPULSE + VBP);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run) begin
      h_cnt <= h_wrap ? '0 : h_cnt + HW'(1);
      if (h_wrap)
        v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
    end
  end

  assign h_active    = (h_cnt >= H_ACT);
  assign v_active    = (v_cnt >= V_ACT);
  assign h_first     = (h_cnt == H_ACT);
  assign hsync       = (h_cnt >= H_SY0) && (h_cnt < H_SY1);
  // v_cnt only moves on the h wrap, so vsync edges land on h_cnt=0
  assign vsync       = (v_cnt >= V_SY0) && (v_cnt < V_SY1);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign frame_last  = h_wrap && v_wrap;

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator and pixel-stream sink: FSM, pixel source mux,
// registered video outputs and underflow status.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   HDISP      = 800,
  parameter int   VDISP      = 480,
  parameter int   HFP        = 40,
  parameter int   HPULSE     = 48,
  parameter int   HBP        = 40,
  parameter int   VFP        = 13,
  parameter int   VPULSE     = 3,
  parameter int   VBP        = 29,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   DATA_WIDTH = 24
) (
  input  logic                  pixel_clk,
  input  logic                  pixel_rst_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] solid_rgb,
  video_timing_gen_if.slave     px,
  output logic                  HS,
  output logic                  VS,
  output logic                  BLANK,
  output logic [DATA_WIDTH-1:0] RGB,
  output logic                  sof,
  output logic                  underflow,
  output logic [15:0]           underflow_cnt,
  input  logic                  clr_status,
  output logic                  running
);

  localparam int CW = DATA_WIDTH / 3;
  localparam int BW = HDISP / 8;
  localparam int PW = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [PW-1:0] B_LAST = PW'(BW - 1);

  logic [1:0] state;
  logic [1:0] state_d;
  mode_e      mode_q;

  logic h_active;
  logic v_active;
  logic h_first;
  logic hsync;
  logic vsync;
  logic frame_start;
  logic frame_last;

  logic run_st;
  logic act;
  logic uf_cyc;
  logic [DATA_WIDTH-1:0] pix_d;

  logic [2:0]    bar_idx;
  logic [PW-1:0] bar_pix;
  logic [2:0]    idx_cur;
  logic [PW-1:0] pix_cur;
  logic [2:0]    bar_c;
  logic [DATA_WIDTH-1:0] bar_px;

  assign run_st  = (state != ST_IDLE);
  assign running = run_st;

  video_raster_cnt #(
    .HDISP  (HDISP),
    .VDISP  (VDISP),
    .HFP    (HFP),
    .HPULSE (HPULSE),
    .HBP    (HBP),
    .VFP    (VFP),
    .VPULSE (VPULSE),
    .VBP    (VBP)
  ) u_raster (
    .clk         (pixel_clk),
    .rst_n       (pixel_rst_n),
    .run         (run_st),
    .clear       (!run_st),
    .h_active    (h_active),
    .v_active    (v_active),
    .h_first     (h_first),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start),
    .frame_last  (frame_last)
  );

  always_comb begin
    state_d = state;
    unique case (1'b1)
      state == ST_IDLE: begin
        if (enable &&
            (mode_e'(mode) != M_STREAM || px.px_valid))
          state_d = ST_RUN;
      end
      state == ST_RUN: begin
        if (!enable)
          state_d = ST_DRAIN;
      end
      // re-enable wins over the end-of-frame stop
      state == ST_DRAIN: begin
        if (enable)
          state_d = ST_RUN;
        else if (frame_last)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state  <= ST_IDLE;
      mode_q <= M_STREAM;
    end else begin
      state <= state_d;
      if (run_st && frame_start)
        mode_q <= mode_e'(mode);
    end
  end

  assign act         = run_st && h_active && v_active;
  assign px.px_ready = act && (mode_q == M_STREAM);

  // bar position restarts on the first active pixel of every line
  assign idx_cur = h_first ? 3'd0 : bar_idx;
  assign pix_cur = h_first ? '0 : bar_pix;
  assign bar_c   = bar_rgb(idx_cur);
  assign bar_px  = {{CW{bar_c[2]}}, {CW{bar_c[1]}}, {CW{bar_c[0]}}};

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      bar_idx <= '0;
      bar_pix <= '0;
    end else if (pix_cur == B_LAST) begin
      bar_idx <= idx_cur + 3'd1;
      bar_pix <= '0;
    end else begin
      bar_idx <= idx_cur;
      bar_pix <= pix_cur + PW'(1);
    end
  end

  always_comb begin
    pix_d  = '0;
    uf_cyc = 1'b0;
    if (act) begin
      unique case (mode_q)
        M_STREAM: begin
          if (px.px_valid)
            pix_d = px.px_data;
          else
            uf_cyc = 1'b1;
        end
        M_BARS:  pix_d = bar_px;
        M_SOLID: pix_d = solid_rgb;
        M_BLACK: pix_d = '0;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      HS    <= ~HS_POL;
      VS    <= ~VS_POL;
      BLANK <= 1'b0;
      RGB   <= '0;
      sof   <= 1'b0;
    end else begin
      HS    <= (run_st && hsync) ? HS_POL : ~HS_POL;
      VS    <= (run_st && vsync) ? VS_POL : ~VS_POL;
      BLANK <= act;
      RGB   <= pix_d;
      sof   <= run_st && frame_start;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (clr_status) begin
      underflow     <= uf_cyc;
      underflow_cnt <= uf_cyc ? 16'd1 : 16'd0;
    end else if (uf_cyc) begin
      underflow <= 1'b1;
      if (underflow_cnt != 16'hFFFF)
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Random-stimulus bench for video_timing_gen: two instances (HDISP 8 and 16)
// checked cycle by cycle against a frame-position reference model.
module tb_video_timing_gen;

  localparam int HF = 2;
  localparam int HP = 2;
  localparam int HB = 2;
  localparam int VF = 1;
  localparam int VP = 1;
  localparam int VB = 1;
  localparam int VD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] solid;
  logic        px_valid;
  logic [23:0] px_data;
  logic        clr;

  logic [1:0]  hs, vs, bl, sof, uf, run, rdy;
  logic [23:0] rgb [2];
  logic [15:0] ucnt [2];

  always #5 clk = ~clk;

  video_timing_gen_if #(.DATA_WIDTH(24)) pif0 ();
  video_timing_gen_if #(.DATA_WIDTH(24)) pif1 ();

  assign pif0.px_valid = px_valid;
  assign pif0.px_data  = px_data;
  assign pif1.px_valid = px_valid;
  assign pif1.px_data  = px_data;
  assign rdy[0] = pif0.px_ready;
  assign rdy[1] = pif1.px_ready;

  video_timing_gen #(
    .HDISP(8), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VFP(VF), .VPULSE(VP), .VBP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_WIDTH(24)
  ) u0 (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .enable(enable),
    .mode(mode), .solid_rgb(solid), .px(pif0),
    .HS(hs[0]), .VS(vs[0]), .BLANK(bl[0]), .RGB(rgb[0]),
    .sof(sof[0]), .underflow(uf[0]), .underflow_cnt(ucnt[0]),
    .clr_status(clr), .running(run[0])
  );

  video_timing_gen #(
    .HDISP(16), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VFP(VF), .VPULSE(VP), .VBP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_WIDTH(24)
  ) u1 (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .enable(enable),
    .mode(mode), .solid_rgb(solid), .px(pif1),
    .HS(hs[1]), .VS(vs[1]), .BLANK(bl[1]), .RGB(rgb[1]),
    .sof(sof[1]), .underflow(uf[1]), .underflow_cnt(ucnt[1]),
    .clr_status(clr), .running(run[1])
  );

  int nvec = 0;
  int nerr = 0;

  int hd [2] = '{8, 16};
  bit on [2];
  int t [2];
  int lm [2];
  bit enp [2];
  bit muf [2];
  int mcnt [2];
  bit e_hs [2], e_vs [2], e_bl [2], e_sof [2], e_rdy [2];
  logic [23:0] e_rgb [2];

  int drop_pct = 0;
  bit rnd_ctl = 0;
  logic [23:0] sdata = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_col(input int b);
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return tbl[b];
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) begin
      on[i] = 0; t[i] = 0; lm[i] = 0; enp[i] = 0;
      muf[i] = 0; mcnt[i] = 0;
      e_hs[i] = 1; e_vs[i] = 1; e_bl[i] = 0;
      e_rgb[i] = '0; e_sof[i] = 0; e_rdy[i] = 0;
    end
  endtask

  // advance the model by one pixel clock using the current inputs
  task automatic mdl(input int i);
    int ht, ft, ha, va, h, v;
    bit act, u;
    logic [23:0] p;
    ht = HF + HP + HB + hd[i];
    ft = ht * (VF + VP + VB + VD);
    ha = HF + HP + HB;
    va = VF + VP + VB;
    h = t[i] % ht;
    v = t[i] / ht;
    act = on[i] && h >= ha && v >= va;
    e_rdy[i] = act && lm[i] == 0;
    u = 0;
    p = '0;
    if (act) begin
      case (lm[i])
        0: if (px_valid) p = px_data; else u = 1;
        1: p = bar_col((h - ha) / (hd[i] / 8));
        2: p = solid;
        default: p = '0;
      endcase
    end
    e_hs[i] = !(on[i] && h >= HF && h < HF + HP);
    e_vs[i] = !(on[i] && v >= VF && v < VF + VP);
    e_bl[i] = act;
    e_rgb[i] = p;
    e_sof[i] = on[i] && t[i] == 0;
    if (clr) begin
      muf[i] = u;
      mcnt[i] = u ? 1 : 0;
    end else if (u) begin
      muf[i] = 1;
      if (mcnt[i] < 65535) mcnt[i]++;
    end
    if (on[i]) begin
      if (t[i] == 0) lm[i] = int'(mode);
      if (!enp[i] && !enable && t[i] == ft - 1) begin
        on[i] = 0;
        t[i] = 0;
      end else begin
        t[i] = (t[i] + 1) % ft;
      end
    end else if (enable && (mode != 2'd0 || px_valid)) begin
      on[i] = 1;
      t[i] = 0;
    end
    enp[i] = enable;
  endtask

  task automatic cmp_all(input int i);
    chk($sformatf("hs%0d", i), 32'(hs[i]), 32'(e_hs[i]));
    chk($sformatf("vs%0d", i), 32'(vs[i]), 32'(e_vs[i]));
    chk($sformatf("blank%0d", i), 32'(bl[i]), 32'(e_bl[i]));
    chk($sformatf("rgb%0d", i), 32'(rgb[i]), 32'(e_rgb[i]));
    chk($sformatf("sof%0d", i), 32'(sof[i]), 32'(e_sof[i]));
    chk($sformatf("running%0d", i), 32'(run[i]), 32'(on[i]));
    chk($sformatf("uflag%0d", i), 32'(uf[i]), 32'(muf[i]));
    chk($sformatf("ucnt%0d", i), 32'(ucnt[i]), 32'(mcnt[i]));
  endtask

  task automatic step();
    px_valid = $urandom_range(0, 99) >= drop_pct;
    px_data  = sdata;
    if (rnd_ctl) begin
      if ($urandom_range(0, 199) == 0) enable = !enable;
      if ($urandom_range(0, 149) == 0) mode = 2'($urandom);
      clr   = $urandom_range(0, 99) == 0;
      solid = 24'($urandom);
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      mdl(i);
      chk($sformatf("px_ready%0d", i), 32'(rdy[i]), 32'(e_rdy[i]));
    end
    @(posedge clk);
    #1;
    if (px_valid && e_rdy[0]) sdata = sdata + 24'd1;
    for (int i = 0; i < 2; i++) cmp_all(i);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst_n = 0; enable = 0; mode = 2'd0; solid = '0;
    px_valid = 0; px_data = '0; clr = 0;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      cmp_all(i);
      chk($sformatf("rdy_rst%0d", i), 32'(rdy[i]), 32'd0);
    end
    rst_n = 1;

    mode = 2'd2; solid = 24'h123456; enable = 1;
    steps(320);

    mode = 2'd0;
    steps(330);

    drop_pct = 5;
    steps(330);
    for (int k = 0; k < 40; k++) begin
      clr = ($urandom_range(0, 3) == 0);
      step();
    end
    clr = 1; drop_pct = 0;
    step();
    clr = 0;
    steps(20);

    mode = 2'd1;
    steps(330);

    mode = 2'd2; solid = 24'($urandom);
    steps(200);
    for (int k = 0; k < 200 && t[0] != 20; k++) step();
    mode = 2'd3;
    for (int k = 0; k < 200 && t[0] != 2 * 14 + 3; k++) step();
    enable = 0;
    steps(330);
    enable = 1;
    steps(200);
    enable = 0;
    steps(330);

    rnd_ctl = 1; drop_pct = 10;
    steps(1500);
    rnd_ctl = 0; clr = 0; drop_pct = 0;

    enable = 1; mode = 2'd2;
    steps(50);
    #3;
    rst_n = 0;
    #1;
    mdl_reset();
    for (int i = 0; i < 2; i++) begin
      cmp_all(i);
      chk($sformatf("rdy_arst%0d", i), 32'(rdy[i]), 32'd0);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) cmp_all(i);
    end
    rst_n = 1;
    mode = 2'd0; drop_pct = 100;
    steps(30);
    drop_pct = 0;
    steps(200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
